// File: rtl/uart_tx_cfg.sv
// UART transmitter with one-word holding register and configurable frame format.
// Define UART_TX_PARITY_EN to add the PARITY state and honour parity_mode.
module uart_tx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic [1:0]           parity_mode,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [3:0]           cnt, cnt_n;
    logic                 scnt, scnt_n;
    logic                 tx_n, done_n, load;

`ifdef UART_TX_PARITY_EN
    logic [1:0] hold_mode;
    logic       par_on, par_bit;
`else
    logic       unused_mode;
    assign unused_mode = ^parity_mode;
`endif

    assign in_ready = !hold_full;
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (in_valid && in_ready) begin
            hold_full <= 1'b1;
            hold_data <= in_data;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity settings travel with the word, not with the live port.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_mode <= 2'b00;
            par_on    <= 1'b0;
            par_bit   <= 1'b0;
        end else begin
            if (in_valid && in_ready)
                hold_mode <= parity_mode;
            if (load) begin
                par_on  <= (hold_mode == 2'b01) || (hold_mode == 2'b10);
                par_bit <= (hold_mode == 2'b01) ? ~^hold_data : ^hold_data;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            scnt      <= 1'b0;
            tx_serial <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            scnt      <= scnt_n;
            tx_serial <= tx_n;
            tx_done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        scnt_n  = scnt;
        tx_n    = tx_serial;
        done_n  = 1'b0;
        load    = 1'b0;
        if (baud_tick) begin
            unique case (state)
                IDLE: begin
                    if (hold_full)
                        load = 1'b1;
                end
                START: begin
                    tx_n    = shreg[0];
                    shreg_n = shreg >> 1;
                    cnt_n   = '0;
                    state_n = DATA;
                end
                DATA: begin
                    if (cnt == LAST_BIT) begin
                        tx_n    = 1'b1;
                        scnt_n  = 1'b0;
                        state_n = STOP;
`ifdef UART_TX_PARITY_EN
                        if (par_on) begin
                            tx_n    = par_bit;
                            state_n = PARITY;
                        end
`endif
                    end else begin
                        tx_n    = shreg[0];
                        shreg_n = shreg >> 1;
                        cnt_n   = cnt + 4'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_n    = 1'b1;
                    scnt_n  = 1'b0;
                    state_n = STOP;
                end
`endif
                STOP: begin
                    if (scnt == LAST_STOP) begin
                        done_n = 1'b1;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // A load always starts the start bit, from IDLE or straight out of STOP.
        if (load) begin
            shreg_n = hold_data;
            tx_n    = 1'b0;
            cnt_n   = '0;
            scnt_n  = 1'b0;
            state_n = START;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized self-checking bench for uart_tx_cfg.
// Two instances: 8 data / 1 stop and 5 data / 2 stop.
module tb_uart_tx_cfg;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, baud_tick;
    logic       va, vb;
    logic [7:0] da;
    logic [4:0] db;
    logic [1:0] pm;
    logic       rdy_a, tx_a, busy_a, done_a;
    logic       rdy_b, tx_b, busy_b, done_b;
    logic       sel;
    logic       o_tx, o_done, o_busy, o_rdy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic tx;
        logic done;
        logic busy;
    } exp_t;

    exp_t q[$];
    bit   prev_frame = 1'b0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .in_valid(va), .in_ready(rdy_a), .in_data(da),
        .parity_mode(pm), .tx_serial(tx_a), .tx_busy(busy_a),
        .tx_done(done_a)
    );

    uart_tx_cfg #(.DATA_BITS(5), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .in_valid(vb), .in_ready(rdy_b), .in_data(db),
        .parity_mode(pm), .tx_serial(tx_b), .tx_busy(busy_b),
        .tx_done(done_b)
    );

    assign o_tx   = sel ? tx_b   : tx_a;
    assign o_done = sel ? done_b : done_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_rdy  = sel ? rdy_b  : rdy_a;

    // Expected line level after each baud tick: start, data LSB first,
    // optional parity making the ones count odd/even, then stop bits.
    function automatic void push_frame(logic [8:0] data, logic [1:0] mode,
                                       int nb, int ns);
        int   ones = 0;
        exp_t e;
        e = '{tx: 1'b0, done: prev_frame, busy: 1'b1};
        q.push_back(e);
        for (int i = 0; i < nb; i++) begin
            e = '{tx: data[i], done: 1'b0, busy: 1'b1};
            ones += int'(data[i]);
            q.push_back(e);
        end
        if (PAR_EN && (mode == 2'b01 || mode == 2'b10)) begin
            e.tx   = (mode == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
            e.done = 1'b0;
            e.busy = 1'b1;
            q.push_back(e);
        end
        for (int i = 0; i < ns; i++) begin
            e = '{tx: 1'b1, done: 1'b0, busy: 1'b1};
            q.push_back(e);
        end
        prev_frame = 1'b1;
    endfunction

    function automatic void push_idle();
        exp_t e;
        e = '{tx: 1'b1, done: prev_frame, busy: 1'b0};
        q.push_back(e);
        prev_frame = 1'b0;
    endfunction

    task automatic pulse_tick();
        @(negedge clk);
        baud_tick = 1'b1;
        @(posedge clk);
        #1;
        baud_tick = 1'b0;
    endtask

    task automatic tick_check(input string name);
        exp_t e;
        logic last;
        last = o_tx;
        repeat (2) begin
            @(negedge clk);
            baud_tick = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (o_tx !== last || o_done !== 1'b0) begin
                failures++;
                $display("FAIL %s gap: tx=%b done=%b, required tx=%b done=0",
                         name, o_tx, o_done, last);
            end
        end
        pulse_tick();
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL %s: expectation queue empty", name);
        end else begin
            e = q.pop_front();
            if (o_tx !== e.tx || o_done !== e.done || o_busy !== e.busy) begin
                failures++;
                $display("FAIL %s tick: tx/done/busy=%b%b%b, required %b%b%b",
                         name, o_tx, o_done, o_busy, e.tx, e.done, e.busy);
            end
        end
    endtask

    task automatic run_queue(input string name);
        while (q.size() > 0) tick_check(name);
    endtask

    task automatic accept(input logic [8:0] data, input logic [1:0] mode,
                          input string name);
        @(negedge clk);
        checks++;
        if (o_rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s ready-before: in_ready=%b, required 1", name, o_rdy);
        end
        da = data[7:0];
        db = data[4:0];
        pm = mode;
        va = (sel == 1'b0);
        vb = (sel == 1'b1);
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
        checks++;
        if (o_rdy !== 1'b0) begin
            failures++;
            $display("FAIL %s ready-after: in_ready=%b, required 0", name, o_rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx_a, busy_a, done_a, rdy_a, tx_b, busy_b, done_b, rdy_b}
            !== 8'b1001_1001) begin
            failures++;
            $display("FAIL reset: a=%b%b%b%b b=%b%b%b%b, required 1001 1001",
                     tx_a, busy_a, done_a, rdy_a, tx_b, busy_b, done_b, rdy_b);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle_ticks();
        sel = 1'b0;
        repeat (4) push_idle();
        run_queue("idle_ticks");
    endtask

    task automatic test_a5();
        sel = 1'b0;
        accept(9'h0A5, 2'b00, "a5");
        push_frame(9'h0A5, 2'b00, 8, 1);
        push_idle();
        run_queue("a5");
    endtask

    task automatic test_parity();
        sel = 1'b0;
        accept(9'h007, 2'b01, "par_odd");
        push_frame(9'h007, 2'b01, 8, 1);
        push_idle();
        run_queue("par_odd");
        accept(9'h007, 2'b10, "par_even");
        pm = 2'b00;
        push_frame(9'h007, 2'b10, 8, 1);
        push_idle();
        run_queue("par_even");
        accept(9'h0FF, 2'b10, "ff_even");
        push_frame(9'h0FF, 2'b10, 8, 1);
        push_idle();
        run_queue("ff_even");
    endtask

    task automatic test_back_to_back();
        int n1;
        sel = 1'b0;
        n1  = (PAR_EN ? 11 : 10);
        accept(9'h055, 2'b01, "b2b_first");
        push_frame(9'h055, 2'b01, 8, 1);
        tick_check("b2b_load");
        accept(9'h00F, 2'b10, "b2b_second");
        push_frame(9'h00F, 2'b10, 8, 1);
        push_idle();
        for (int i = 1; q.size() > 0; i++) begin
            tick_check("b2b");
            checks++;
            if (o_rdy !== (i >= n1)) begin
                failures++;
                $display("FAIL b2b ready tick %0d: in_ready=%b, required %b",
                         i, o_rdy, (i >= n1));
            end
        end
    endtask

    task automatic test_five_two();
        sel = 1'b1;
        accept(9'h013, 2'b00, "b_13");
        push_frame(9'h013, 2'b00, 5, 2);
        push_idle();
        run_queue("b_13");
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        accept(9'h03C, 2'b00, "rst_mid");
        repeat (5) pulse_tick();
        accept(9'h081, 2'b00, "rst_pending");
        @(negedge clk);
        rst       = 1'b1;
        baud_tick = 1'b1;
        va        = 1'b1;
        @(posedge clk);
        #1;
        va        = 1'b0;
        baud_tick = 1'b0;
        checks++;
        if ({tx_a, rdy_a, busy_a, done_a} !== 4'b1100) begin
            failures++;
            $display("FAIL rst_mid: tx/rdy/busy/done=%b%b%b%b, required 1100",
                     tx_a, rdy_a, busy_a, done_a);
        end
        @(negedge clk);
        rst = 1'b0;
        prev_frame = 1'b0;
        repeat (15) push_idle();
        run_queue("rst_after");
    endtask

    task automatic test_random();
        logic [8:0] d;
        logic [1:0] m;
        for (int n = 0; n < 20; n++) begin
            sel = 1'($urandom_range(0, 1));
            d   = 9'($urandom_range(0, 255));
            m   = 2'($urandom_range(0, 3));
            accept(d, m, "rand");
            pm = 2'($urandom_range(0, 3));
            if (sel) push_frame({4'b0, d[4:0]}, m, 5, 2);
            else     push_frame(d, m, 8, 1);
            push_idle();
            run_queue("rand");
        end
    endtask

    initial begin
        rst       = 1'b1;
        baud_tick = 1'b0;
        va        = 1'b0;
        vb        = 1'b0;
        da        = '0;
        db        = '0;
        pm        = 2'b00;
        sel       = 1'b0;
        test_reset();
        test_idle_ticks();
        test_a5();
        test_parity();
        test_back_to_back();
        test_five_two();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port baud_tick  input  1  one-clk pulse marking each bit boundary.
REQ-006 SHALL have port in_valid  input  1  in_data is offered.
REQ-007 SHALL have port in_ready  output  1  holding register empty and accepting.
REQ-008 SHALL have port in_data  input  DATA_BITS  frame payload, LSB sent first.
REQ-009 SHALL have port parity_mode  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-010 SHALL have port tx_serial  output  1  serial line, idle high.
REQ-011 SHALL have port tx_busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port tx_done  output  1  one-clk pulse at end of last stop bit.

Function
REQ-013 SHALL accept a word when in_valid && in_ready at a clk edge, storing in_data and parity_mode in a one-entry holding register.
REQ-014 SHALL hold in_ready low while the holding register is full, and raise it on the clk edge after the holding register is transferred to the shift register.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; every state change SHALL occur only on a clk edge where baud_tick is high.
REQ-016 In IDLE with the holding register full and baud_tick high, SHALL load the shift register, empty the holding register, drive tx_serial=0, and enter START.
REQ-017 In START on baud_tick, SHALL drive tx_serial=data bit 0, clear the bit counter, and enter DATA.
REQ-018 In DATA on baud_tick, SHALL drive the next data bit and increment the counter until DATA_BITS bits have been sent; after the last bit, SHALL enter PARITY if parity is active, otherwise STOP.
REQ-019 On entering PARITY, SHALL drive the parity bit (odd: XNOR-reduce of the data; even: XOR-reduce of the data); on baud_tick, SHALL enter STOP.
REQ-020 On entering STOP, SHALL drive tx_serial=1 and hold it for STOP_BITS baud intervals.
REQ-021 On the final STOP baud_tick, SHALL pulse tx_done for one clk.
REQ-021a On the same final STOP baud_tick, SHALL go directly to START (tx_serial=0, load) if the holding register is full, giving no idle gap; otherwise it SHALL go to IDLE.
REQ-022 SHALL ignore baud_tick pulses in IDLE while the holding register is empty; tx_serial SHALL remain 1.
REQ-023 SHALL use the parity_mode captured with each word; changes on the port mid-frame SHALL have no effect.
REQ-024 An accept in the same cycle as a load SHALL not occur, because in_ready is low during that cycle.
REQ-025 Each bit SHALL last exactly one baud_tick interval; the frame length SHALL be 1 + DATA_BITS + P + STOP_BITS intervals, where P is 0 or 1.

Reset
REQ-026 When rst is high at a clk edge, SHALL force state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, in_ready=1, holding register empty, and all counters 0.
REQ-027 Reset mid-frame SHALL abort the frame, return the line high on the next edge, and discard both the current and the pending word.
REQ-028 rst SHALL take priority over in_valid and baud_tick in the same cycle.

Configuration
REQ-029 With macro UART_TX_PARITY_EN defined, SHALL include the PARITY state and honour parity_mode.
REQ-030 Without UART_TX_PARITY_EN, the PARITY state SHALL be absent, parity_mode SHALL remain a port but be ignored, and frames SHALL never contain a parity bit.

Verification
REQ-031 DATA_BITS=8, STOP_BITS=1, mode 00, send 0xA5 -> line bits 0,1,0,1,0,0,1,0,1,1 over 10 ticks; one tx_done pulse.
REQ-032 Macro defined, mode 01, send 0x07 (three ones) -> parity bit 0; mode 10 -> parity bit 1; frame of 11 ticks.
REQ-033 Send 0x55 then 0x0F back-to-back, the second accepted during the first frame -> second start bit begins on the tick ending the first stop bit; in_ready low until the second word loads.
REQ-034 DATA_BITS=5, STOP_BITS=2, send 0x13 -> bits 0,1,1,0,0,1,1,1; tx_done after the second stop tick.
REQ-035 Assert rst during DATA bit 3 with a word pending -> tx_serial=1, in_ready=1, tx_busy=0 next edge; no tx_done; line stays idle afterwards.
REQ-036 Macro undefined, mode 10, send 0xFF -> no parity bit; frame of 10 ticks.
